// File: rtl/door_lock_ctrl.sv
// Passcode door lock: digit entry, check, timed unlock, retry lockout.
// Optional passcode reprogramming from the unlocked state is enabled by DOOR_LOCK_PROG_EN.
module door_lock_ctrl #(
    parameter int DIGIT_W     = 2,
    parameter int NUM_DIGITS  = 8,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0] RESET_CODE = '1,
    parameter int MAX_TRIES   = 3,
    parameter int LOCKOUT_CYC = 1024,
    parameter int UNLOCK_CYC  = 256,
    localparam int CODE_W     = DIGIT_W * NUM_DIGITS,
    localparam int TRIES_W    = $clog2(MAX_TRIES + 1),
    localparam int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               clear,
    input  logic               prog_req,
    output logic               unlock,
    output logic               fail,
    output logic               lockout,
    output logic               prog_done,
    output logic [TRIES_W-1:0] tries_left,
    output logic [CNT_W-1:0]   entry_cnt
);

    localparam int TMR_MAX = (LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_OPEN,
        S_LOCKOUT,
        S_PROG
    } state_t;

    state_t             state_q, state_d;
    logic [CODE_W-1:0]  buf_q, buf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TRIES_W-1:0] tries_q, tries_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               unlock_q, unlock_d;
    logic               fail_q, fail_d;
    logic               lockout_q, lockout_d;
    logic [CODE_W-1:0]  code_q;

    logic [CODE_W-1:0]  buf_shift;
    logic [CNT_W-1:0]   cnt_inc;

    assign buf_shift = (buf_q << DIGIT_W) | CODE_W'(digit);
    assign cnt_inc   = cnt_q + 1'b1;

`ifdef DOOR_LOCK_PROG_EN
    logic [CODE_W-1:0] code_d;
    logic              prog_done_q, prog_done_d;
`else
    logic unused_prog_req;
    assign unused_prog_req = prog_req;
    assign code_q          = RESET_CODE;
`endif

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        tries_d   = tries_q;
        tmr_d     = tmr_q;
        unlock_d  = unlock_q;
        lockout_d = lockout_q;
        fail_d    = 1'b0;
`ifdef DOOR_LOCK_PROG_EN
        code_d      = code_q;
        prog_done_d = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_ENTRY: begin
                // clear beats a simultaneous digit
                if (clear) begin
                    cnt_d   = '0;
                    buf_d   = '0;
                    state_d = S_IDLE;
                end else if (digit_valid) begin
                    buf_d   = buf_shift;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == CNT_W'(NUM_DIGITS)) ? S_CHECK : S_ENTRY;
                end
            end
            S_CHECK: begin
                cnt_d = '0;
                buf_d = '0;
                if (buf_q == code_q) begin
                    state_d  = S_OPEN;
                    unlock_d = 1'b1;
                    tmr_d    = TMR_W'(UNLOCK_CYC - 1);
                    tries_d  = TRIES_W'(MAX_TRIES);
                end else begin
                    fail_d  = 1'b1;
                    tries_d = tries_q - 1'b1;
                    if (tries_q == TRIES_W'(1)) begin
                        state_d   = S_LOCKOUT;
                        lockout_d = 1'b1;
                        tmr_d     = TMR_W'(LOCKOUT_CYC - 1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_OPEN: begin
`ifdef DOOR_LOCK_PROG_EN
                if (prog_req) begin
                    state_d  = S_PROG;
                    unlock_d = 1'b0;
                end else
`endif
                if (tmr_q == '0) begin
                    state_d  = S_IDLE;
                    unlock_d = 1'b0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_LOCKOUT: begin
                if (tmr_q == '0) begin
                    state_d   = S_IDLE;
                    lockout_d = 1'b0;
                    tries_d   = TRIES_W'(MAX_TRIES);
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_PROG: begin
`ifdef DOOR_LOCK_PROG_EN
                // A full buffer is committed one cycle after the last digit
                if (cnt_q == CNT_W'(NUM_DIGITS)) begin
                    code_d      = buf_q;
                    prog_done_d = 1'b1;
                    cnt_d       = '0;
                    buf_d       = '0;
                    state_d     = S_IDLE;
                end else if (clear) begin
                    cnt_d   = '0;
                    buf_d   = '0;
                    state_d = S_IDLE;
                end else if (digit_valid) begin
                    buf_d = buf_shift;
                    cnt_d = cnt_inc;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            buf_q     <= '0;
            cnt_q     <= '0;
            tries_q   <= TRIES_W'(MAX_TRIES);
            tmr_q     <= '0;
            unlock_q  <= 1'b0;
            fail_q    <= 1'b0;
            lockout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            tries_q   <= tries_d;
            tmr_q     <= tmr_d;
            unlock_q  <= unlock_d;
            fail_q    <= fail_d;
            lockout_q <= lockout_d;
        end
    end

`ifdef DOOR_LOCK_PROG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q      <= RESET_CODE;
            prog_done_q <= 1'b0;
        end else begin
            code_q      <= code_d;
            prog_done_q <= prog_done_d;
        end
    end
    assign prog_done = prog_done_q;
`else
    assign prog_done = 1'b0;
`endif

    assign unlock     = unlock_q;
    assign fail       = fail_q;
    assign lockout    = lockout_q;
    assign tries_left = tries_q;
    assign entry_cnt  = cnt_q;

endmodule

// File: tb/tb_door_lock_ctrl.sv
// Self-checking bench for door_lock_ctrl: directed scenarios plus random traffic
// compared every cycle against an event-level model of the lock.
module tb_door_lock_ctrl;

    localparam int DIGIT_W     = 2;
    localparam int NUM_DIGITS  = 8;
    localparam int MAX_TRIES   = 3;
    localparam int LOCKOUT_CYC = 1024;
    localparam int UNLOCK_CYC  = 256;
`ifdef DOOR_LOCK_PROG_EN
    localparam bit PROG_EN = 1'b1;
`else
    localparam bit PROG_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       digit_valid = 1'b0;
    logic [1:0] digit = 2'd0;
    logic       clear = 1'b0;
    logic       prog_req = 1'b0;
    logic       unlock, fail, lockout, prog_done;
    logic [1:0] tries_left;
    logic [3:0] entry_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    door_lock_ctrl #(
        .DIGIT_W    (DIGIT_W),
        .NUM_DIGITS (NUM_DIGITS),
        .RESET_CODE (16'hFFFF),
        .MAX_TRIES  (MAX_TRIES),
        .LOCKOUT_CYC(LOCKOUT_CYC),
        .UNLOCK_CYC (UNLOCK_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit_valid(digit_valid),
        .digit      (digit),
        .clear      (clear),
        .prog_req   (prog_req),
        .unlock     (unlock),
        .fail       (fail),
        .lockout    (lockout),
        .prog_done  (prog_done),
        .tries_left (tries_left),
        .entry_cnt  (entry_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural model: digits held in a queue, timed phases as countdowns.
    int          m_q[$];
    int          m_prog_q[$];
    bit          m_pend_check, m_pend_commit, m_prog;
    int          m_unlock_left, m_lock_left, m_tries;
    bit          m_fail, m_pdone;
    logic [15:0] m_code;

    function automatic logic [15:0] pack_digits(input bit from_prog);
        logic [15:0] v = 16'd0;
        if (from_prog) foreach (m_prog_q[i]) v = (v << 2) | 16'(m_prog_q[i]);
        else           foreach (m_q[i])      v = (v << 2) | 16'(m_q[i]);
        return v;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_prog_q.delete();
        m_pend_check  = 0;
        m_pend_commit = 0;
        m_prog        = 0;
        m_unlock_left = 0;
        m_lock_left   = 0;
        m_tries       = MAX_TRIES;
        m_fail        = 0;
        m_pdone       = 0;
        m_code        = 16'hFFFF;
    endtask

    task automatic model_step();
        m_fail  = 0;
        m_pdone = 0;
        if (m_pend_check) begin
            m_pend_check = 0;
            if (pack_digits(1'b0) == m_code) begin
                m_unlock_left = UNLOCK_CYC;
                m_tries       = MAX_TRIES;
            end else begin
                m_fail  = 1;
                m_tries = m_tries - 1;
                if (m_tries == 0) m_lock_left = LOCKOUT_CYC;
            end
            m_q.delete();
        end else if (m_pend_commit) begin
            m_code        = pack_digits(1'b1);
            m_pdone       = 1;
            m_pend_commit = 0;
            m_prog        = 0;
            m_prog_q.delete();
        end else if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_tries = MAX_TRIES;
        end else if (m_unlock_left > 0) begin
            if (PROG_EN && prog_req) begin
                m_unlock_left = 0;
                m_prog        = 1;
            end else begin
                m_unlock_left--;
            end
        end else if (m_prog) begin
            if (clear) begin
                m_prog = 0;
                m_prog_q.delete();
            end else if (digit_valid) begin
                m_prog_q.push_back(int'(digit));
                if (m_prog_q.size() == NUM_DIGITS) m_pend_commit = 1;
            end
        end else begin
            if (clear) m_q.delete();
            else if (digit_valid) begin
                m_q.push_back(int'(digit));
                if (m_q.size() == NUM_DIGITS) m_pend_check = 1;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    function automatic int m_entry_cnt();
        return m_prog ? m_prog_q.size() : m_q.size();
    endfunction

    always @(negedge clk) begin
        check("unlock", unlock, m_unlock_left > 0);
        check("lockout", lockout, m_lock_left > 0);
        check("fail", fail, m_fail);
        check("prog_done", prog_done, m_pdone);
        check("tries_left", tries_left, m_tries);
        check("entry_cnt", entry_cnt, m_entry_cnt());
        check("unlock_lockout_excl", unlock & lockout, 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enter(input int first, input int last);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_valid = 1'b1;
            digit       = 2'((i == NUM_DIGITS - 1) ? last : first);
            step();
        end
        digit_valid = 1'b0;
    endtask

    task automatic run_out_unlock(input string name);
        int n = 0;
        while (unlock === 1'b1 && n < UNLOCK_CYC + 10) begin
            n++;
            step();
        end
        check(name, n, UNLOCK_CYC);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2 rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check("reset_tries", tries_left, 3);
        check("reset_entry_cnt", entry_cnt, 0);
        check("reset_unlock", unlock, 0);

        // Correct code: unlock two cycles after the last digit, 256 cycles long
        enter(3, 3);
        check("check_cycle_unlock", unlock, 0);
        check("check_cycle_cnt", entry_cnt, 8);
        step();
        check("unlock_rise", unlock, 1);
        check("open_tries", tries_left, 3);
        check("open_entry_cnt", entry_cnt, 0);
        run_out_unlock("unlock_len");

        // Three wrong codes lead to lockout; digits ignored while locked
        for (int k = 1; k <= 3; k++) begin
            enter(3, 2);
            step();
            check("fail_pulse", fail, 1);
            check("tries_after_fail", tries_left, 3 - k);
            if (k < 3) begin
                step();
                check("fail_single", fail, 0);
            end
        end
        check("lockout_rise", lockout, 1);
        n = 0;
        while (lockout === 1'b1 && n < LOCKOUT_CYC + 10) begin
            digit_valid = 1'b1;
            digit       = 2'd3;
            n++;
            step();
        end
        digit_valid = 1'b0;
        check("lockout_len", n, LOCKOUT_CYC);
        check("lockout_reload", tries_left, 3);
        check("lockout_entry_cnt", entry_cnt, 0);

        // Partial entry aborted by clear (with a simultaneous digit)
        for (int i = 0; i < 3; i++) begin
            digit_valid = 1'b1;
            digit       = 2'd3;
            step();
        end
        check("partial_cnt", entry_cnt, 3);
        clear = 1'b1;
        step();
        clear       = 1'b0;
        digit_valid = 1'b0;
        check("clear_cnt", entry_cnt, 0);
        enter(3, 3);
        step();
        check("clear_then_unlock", unlock, 1);
        check("clear_tries", tries_left, 3);
        run_out_unlock("unlock_len2");

        // Two wrong codes then the right one reloads tries
        enter(1, 1);
        step();
        enter(3, 2);
        step();
        check("two_wrong_tries", tries_left, 1);
        enter(3, 3);
        step();
        check("reload_unlock", unlock, 1);
        check("reload_tries", tries_left, 3);
        run_out_unlock("unlock_len3");

`ifdef DOOR_LOCK_PROG_EN
        enter(3, 3);
        step();
        step();
        prog_req = 1'b1;
        step();
        prog_req = 1'b0;
        check("prog_unlock_drop", unlock, 0);
        enter(1, 1);
        check("prog_done_wait", prog_done, 0);
        step();
        check("prog_done_pulse", prog_done, 1);
        step();
        check("prog_done_single", prog_done, 0);
        enter(3, 3);
        step();
        check("old_code_fails", fail, 1);
        enter(1, 1);
        step();
        check("new_code_unlocks", unlock, 1);
        run_out_unlock("unlock_len4");
`endif

        // Reset mid-lockout clears immediately and restores the reset code
        for (int k = 0; k < 3; k++) begin
            enter(0, 1);
            step();
        end
        step();
        step();
        check("pre_reset_lockout", lockout, 1);
        rst_n = 1'b0;
        #1;
        check("async_lockout", lockout, 0);
        check("async_tries", tries_left, 3);
        check("async_unlock", unlock, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        enter(3, 3);
        step();
        check("code_reverted", unlock, 1);
        run_out_unlock("unlock_len5");

        // Random traffic checked by the model every cycle
        for (int i = 0; i < 20000; i++) begin
            digit_valid = ($urandom % 3) != 0;
            digit       = ($urandom % 5 == 0) ? 2'($urandom % 4) : 2'd3;
            clear       = ($urandom % 40) == 0;
            prog_req    = ($urandom % 25) == 0;
            if (i == 10000) rst_n = 1'b0;
            if (i == 10001) rst_n = 1'b1;
            step();
        end
        digit_valid = 1'b0;
        clear       = 1'b0;
        prog_req    = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/door_lock_ctrl.md
DOOR_LOCK_CTRL -- requirements
Module: door_lock_ctrl

Interface
REQ-001 SHALL have parameter DIGIT_W, default 2: bits per passcode digit.
REQ-002 SHALL have parameter NUM_DIGITS, default 8: digits per passcode; CODE_W = DIGIT_W*NUM_DIGITS.
REQ-003 SHALL have parameter RESET_CODE, default all-ones (CODE_W bits): passcode after reset.
REQ-004 SHALL have parameter MAX_TRIES, default 3: wrong attempts allowed before lockout; at least 1.
REQ-005 SHALL have parameter LOCKOUT_CYC, default 1024: lockout duration in clk cycles; at least 1.
REQ-006 SHALL have parameter UNLOCK_CYC, default 256: unlock hold time in clk cycles; at least 1.
REQ-007 SHALL have ports clk in 1, the single clock, and rst_n in 1, the asynchronous active-low reset.
REQ-008 SHALL have port digit_valid in 1: digit strobe, sampled on rising clk.
REQ-009 SHALL have port digit in DIGIT_W: digit value, qualified by digit_valid.
REQ-010 SHALL have port clear in 1: abort the current entry.
REQ-011 SHALL have port prog_req in 1: request passcode reprogramming.
REQ-012 SHALL have outputs unlock 1, fail 1, lockout 1, prog_done 1, tries_left clog2(MAX_TRIES+1) and entry_cnt clog2(NUM_DIGITS+1), all registered.

Function
REQ-013 SHALL implement states IDLE, ENTRY, CHECK, OPEN, LOCKOUT and PROG.
REQ-014 In IDLE or ENTRY, an accepted digit SHALL shift into the entry buffer (first digit = MS digit) and increment entry_cnt; IDLE then moves to ENTRY.
REQ-015 Accepting digit NUM_DIGITS SHALL move the block to CHECK on the next cycle; CHECK SHALL last exactly one cycle and set entry_cnt to 0.
REQ-016 If CHECK matches the stored code, the block SHALL go to OPEN, assert unlock (two cycles after the last digit) for exactly UNLOCK_CYC cycles, reload tries_left to MAX_TRIES, then return to IDLE.
REQ-017 If CHECK mismatches, the block SHALL pulse fail for one cycle (two cycles after the last digit) and decrement tries_left.
REQ-018 After a mismatch, if tries_left is still nonzero the block SHALL return to IDLE; if it reaches 0 the block SHALL enter LOCKOUT.
REQ-019 LOCKOUT SHALL hold lockout=1 for exactly LOCKOUT_CYC cycles, then reload tries_left to MAX_TRIES and return to IDLE.
REQ-020 digit_valid SHALL be ignored in CHECK, OPEN and LOCKOUT; clear SHALL be ignored in CHECK and LOCKOUT.
REQ-021 clear in ENTRY SHALL zero entry_cnt, discard the buffer, return to IDLE and consume no try; clear together with digit_valid SHALL mean the clear wins.
REQ-022 unlock and lockout SHALL never both be 1; fail and prog_done SHALL be single-cycle pulses.

Reset
REQ-023 rst_n low SHALL immediately force IDLE: unlock, fail, lockout and prog_done = 0; entry_cnt = 0; tries_left = MAX_TRIES; entry buffer cleared; stored code = RESET_CODE.
REQ-024 Reset during OPEN, LOCKOUT, PROG or ENTRY SHALL abort that state with no further pulse.

Configuration
REQ-025 With macro DOOR_LOCK_PROG_EN defined, prog_req sampled in OPEN SHALL move the block to PROG and deassert unlock on the next cycle.
REQ-026 With DOOR_LOCK_PROG_EN defined, in PROG the next NUM_DIGITS accepted digits SHALL fill entry_cnt and the buffer; after the last, the stored code SHALL be updated, prog_done SHALL pulse, and the block SHALL go to IDLE.
REQ-027 With DOOR_LOCK_PROG_EN defined, clear in PROG SHALL leave the stored code unchanged and return to IDLE.
REQ-028 Without DOOR_LOCK_PROG_EN, the stored code SHALL be the constant RESET_CODE, prog_req SHALL be ignored, prog_done SHALL be tied 0, and PROG SHALL be unreachable.

Verification (defaults, code = eight digits of 3)
REQ-029 Eight 3s -> unlock=1 from 2 cycles after the 8th digit for 256 cycles; tries_left=3.
REQ-030 Seven 3s then a 2, three times -> fail pulses; tries_left goes 2,1,0; lockout=1 for 1024 cycles with digits ignored; afterwards tries_left=3.
REQ-031 Three 3s, then clear, then eight 3s -> unlock; tries_left stays 3; entry_cnt resets to 0 on clear.
REQ-032 Two wrong codes, then the correct code -> unlock=1 and tries_left reloads from 1 to 3.
REQ-033 With DOOR_LOCK_PROG_EN: unlock, prog_req, eight 1s -> prog_done pulse; afterwards eight 3s gives fail and eight 1s gives unlock.
REQ-034 rst_n low mid-LOCKOUT -> lockout=0 immediately, tries_left=3, stored code reverts to RESET_CODE.
